// File: rtl/biriscv_inst_encoder.sv
// Builds legal RV32I opcode words from an op class plus register/immediate fields,
// expands LI into LUI+ADDI and buffers results in a 2-entry first-word-registered FIFO.
module biriscv_inst_encoder #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [3:0]       req_op_i,
  input  logic [4:0]       req_rd_i,
  input  logic [4:0]       req_rs1_i,
  input  logic [4:0]       req_rs2_i,
  input  logic [31:0]      req_imm_i,
  output logic             out_valid_o,
  output logic [31:0]      out_opcode_o,
  input  logic             out_accept_i,
  output logic             err_o,
  output logic [CNT_W-1:0] enc_count_o
);

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_AND   = 4'd2,
    OP_OR    = 4'd3,
    OP_XOR   = 4'd4,
    OP_SLL   = 4'd5,
    OP_SRL   = 4'd6,
    OP_SRA   = 4'd7,
    OP_ADDI  = 4'd8,
    OP_LUI   = 4'd9,
    OP_LW    = 4'd10,
    OP_SW    = 4'd11,
    OP_BEQ   = 4'd12,
    OP_JAL   = 4'd13,
    OP_LI    = 4'd14,
    OP_CSRRW = 4'd15
  } op_e;

  typedef enum logic {
    ST_IDLE,
    ST_LI_LO
  } state_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_ALT  = 7'h20;

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, OPC_OP};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] opc);
    return {imm, rs1, f3, rd, opc};
  endfunction

  op_e               op;
  state_e            state_reg, state_next;
  logic [31:0]       fifo_mem_reg [2];
  logic              wr_ptr_reg, rd_ptr_reg;
  logic [1:0]        count_reg, count_next;
  logic              err_reg, err_next;
  logic [CNT_W-1:0]  enc_count_reg;
  logic [11:0]       li_lo_reg;
  logic [4:0]        li_rd_reg;

  logic [31:0]       enc_word;
  logic              enc_ok;
  logic              li_split;
  logic              fits_s12, fits_b, fits_j;
  logic [19:0]       li_hi;
  logic              pop, accept, push;
  logic [31:0]       push_word;
  logic [1:0]        slot_we;

  assign op = op_e'(req_op_i);

  // Range predicates: upper bits must all equal the sign bit of the field.
  assign fits_s12 = (req_imm_i[31:11] == '0) || (req_imm_i[31:11] == '1);
  assign fits_b   = !req_imm_i[0] && ((req_imm_i[31:12] == '0) || (req_imm_i[31:12] == '1));
  assign fits_j   = !req_imm_i[0] && ((req_imm_i[31:20] == '0) || (req_imm_i[31:20] == '1));

  // (imm + 0x800) >> 12 without a 32-bit adder: round the upper field by bit 11.
  assign li_hi = req_imm_i[31:12] + {19'd0, req_imm_i[11]};

  always_comb begin
    enc_word = '0;
    enc_ok   = 1'b1;
    li_split = 1'b0;
    case (op)
      OP_ADD:  enc_word = enc_r(F7_BASE, req_rs2_i, req_rs1_i, 3'b000, req_rd_i);
      OP_SUB:  enc_word = enc_r(F7_ALT,  req_rs2_i, req_rs1_i, 3'b000, req_rd_i);
      OP_AND:  enc_word = enc_r(F7_BASE, req_rs2_i, req_rs1_i, 3'b111, req_rd_i);
      OP_OR:   enc_word = enc_r(F7_BASE, req_rs2_i, req_rs1_i, 3'b110, req_rd_i);
      OP_XOR:  enc_word = enc_r(F7_BASE, req_rs2_i, req_rs1_i, 3'b100, req_rd_i);
      OP_SLL:  enc_word = enc_r(F7_BASE, req_rs2_i, req_rs1_i, 3'b001, req_rd_i);
      OP_SRL:  enc_word = enc_r(F7_BASE, req_rs2_i, req_rs1_i, 3'b101, req_rd_i);
      OP_SRA:  enc_word = enc_r(F7_ALT,  req_rs2_i, req_rs1_i, 3'b101, req_rd_i);
      OP_ADDI: begin
        enc_word = enc_i(req_imm_i[11:0], req_rs1_i, 3'b000, req_rd_i, OPC_OPIMM);
        enc_ok   = fits_s12;
      end
      OP_LUI: begin
        enc_word = {req_imm_i[31:12], req_rd_i, OPC_LUI};
        enc_ok   = (req_imm_i[11:0] == 12'd0);
      end
      OP_LW: begin
        enc_word = enc_i(req_imm_i[11:0], req_rs1_i, 3'b010, req_rd_i, OPC_LOAD);
        enc_ok   = fits_s12;
      end
      OP_SW: begin
        enc_word = {req_imm_i[11:5], req_rs2_i, req_rs1_i, 3'b010, req_imm_i[4:0], OPC_STORE};
        enc_ok   = fits_s12;
      end
      OP_BEQ: begin
        enc_word = {req_imm_i[12], req_imm_i[10:5], req_rs2_i, req_rs1_i, 3'b000,
                    req_imm_i[4:1], req_imm_i[11], OPC_BRANCH};
        enc_ok   = fits_b;
      end
      OP_JAL: begin
        enc_word = {req_imm_i[20], req_imm_i[10:1], req_imm_i[11], req_imm_i[19:12],
                    req_rd_i, OPC_JAL};
        enc_ok   = fits_j;
      end
      OP_LI: begin
        if (fits_s12) begin
          enc_word = enc_i(req_imm_i[11:0], 5'd0, 3'b000, req_rd_i, OPC_OPIMM);
        end else begin
          enc_word = {li_hi, req_rd_i, OPC_LUI};
          li_split = (req_imm_i[11:0] != 12'd0);
        end
      end
      OP_CSRRW: begin
        enc_word = enc_i(req_imm_i[11:0], req_rs1_i, 3'b001, req_rd_i, OPC_SYSTEM);
        enc_ok   = (req_imm_i[31:12] == 20'd0);
      end
      default: enc_word = '0;
    endcase
  end

  // Accept only when every word the request can produce already has a slot.
  assign pop         = out_accept_i && (count_reg != 2'd0);
  assign req_ready_o = (state_reg == ST_IDLE) &&
                       ((count_reg == 2'd0) || ((count_reg == 2'd1) && pop));
  assign accept      = req_valid_i && req_ready_o;

  always_comb begin
    state_next = state_reg;
    push       = 1'b0;
    push_word  = enc_word;
    err_next   = 1'b0;
    case (state_reg)
      ST_LI_LO: begin
        push       = 1'b1;
        push_word  = enc_i(li_lo_reg, li_rd_reg, 3'b000, li_rd_reg, OPC_OPIMM);
        state_next = ST_IDLE;
      end
      default: begin
        if (accept) begin
          if (enc_ok) begin
            push = 1'b1;
          end else begin
            err_next = 1'b1;
          end
          if (li_split) begin
            state_next = ST_LI_LO;
          end
        end
      end
    endcase
  end

  assign count_next = count_reg + {1'b0, push} - {1'b0, pop};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_slot_we
      assign slot_we[gi] = push && (wr_ptr_reg == 1'(gi));
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < 2; i++) begin
        fifo_mem_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (slot_we[i]) begin
          fifo_mem_reg[i] <= push_word;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_reg     <= ST_IDLE;
      count_reg     <= 2'd0;
      wr_ptr_reg    <= 1'b0;
      rd_ptr_reg    <= 1'b0;
      err_reg       <= 1'b0;
      enc_count_reg <= '0;
      li_lo_reg     <= '0;
      li_rd_reg     <= '0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      err_reg   <= err_next;
      if (push) begin
        wr_ptr_reg    <= ~wr_ptr_reg;
        enc_count_reg <= enc_count_reg + CNT_W'(1);
      end
      if (pop) begin
        rd_ptr_reg <= ~rd_ptr_reg;
      end
      if (accept && li_split) begin
        li_lo_reg <= req_imm_i[11:0];
        li_rd_reg <= req_rd_i;
      end
    end
  end

  assign out_valid_o  = (count_reg != 2'd0);
  assign out_opcode_o = fifo_mem_reg[rd_ptr_reg];
  assign err_o        = err_reg;
  assign enc_count_o  = enc_count_reg;

endmodule

// File: tb/tb_biriscv_inst_encoder.sv
// Self-checking bench for biriscv_inst_encoder: directed scenarios plus a randomized
// run scored against an arithmetic instruction-format model and an expected-word queue.
module tb_biriscv_inst_encoder;
  localparam int CNT_W = 16;

  logic             clk_i, rst_ni;
  logic             req_valid_i, req_ready_o;
  logic [3:0]       req_op_i;
  logic [4:0]       req_rd_i, req_rs1_i, req_rs2_i;
  logic [31:0]      req_imm_i;
  logic             out_valid_o, out_accept_i, err_o;
  logic [31:0]      out_opcode_o;
  logic [CNT_W-1:0] enc_count_o;

  int checks = 0;
  int errors = 0;

  biriscv_inst_encoder #(.CNT_W(CNT_W)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_op_i     (req_op_i),
    .req_rd_i     (req_rd_i),
    .req_rs1_i    (req_rs1_i),
    .req_rs2_i    (req_rs2_i),
    .req_imm_i    (req_imm_i),
    .out_valid_o  (out_valid_o),
    .out_opcode_o (out_opcode_o),
    .out_accept_i (out_accept_i),
    .err_o        (err_o),
    .enc_count_o  (enc_count_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Reference: builds words field by field with shifts/masks from the ISA formats.
  function automatic void model_encode(input logic [3:0] op, input logic [31:0] rd,
                                       input logic [31:0] rs1, input logic [31:0] rs2,
                                       input logic [31:0] imm, output logic [31:0] w0,
                                       output logic [31:0] w1, output int nw, output bit bad);
    logic [31:0] u, f3, f7, hi, lo;
    int s;
    u = imm;
    s = $signed(imm);
    w0 = 32'h0; w1 = 32'h0; nw = 1; bad = 1'b0;
    if (op <= 4'd7) begin
      case (op)
        4'd2: f3 = 32'd7;
        4'd3: f3 = 32'd6;
        4'd4: f3 = 32'd4;
        4'd5: f3 = 32'd1;
        4'd6, 4'd7: f3 = 32'd5;
        default: f3 = 32'd0;
      endcase
      f7 = (op == 4'd1 || op == 4'd7) ? 32'd32 : 32'd0;
      w0 = (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h33;
    end else begin
      case (op)
        4'd8: begin
          bad = !(s >= -2048 && s <= 2047);
          w0 = ((u & 32'hFFF) << 20) | (rs1 << 15) | (rd << 7) | 32'h13;
        end
        4'd9: begin
          bad = (u & 32'hFFF) != 32'h0;
          w0 = (u & 32'hFFFFF000) | (rd << 7) | 32'h37;
        end
        4'd10: begin
          bad = !(s >= -2048 && s <= 2047);
          w0 = ((u & 32'hFFF) << 20) | (rs1 << 15) | (32'd2 << 12) | (rd << 7) | 32'h03;
        end
        4'd11: begin
          bad = !(s >= -2048 && s <= 2047);
          w0 = (((u >> 5) & 32'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (32'd2 << 12) |
               ((u & 32'h1F) << 7) | 32'h23;
        end
        4'd12: begin
          bad = u[0] || s < -4096 || s > 4094;
          w0 = (((u >> 12) & 32'h1) << 31) | (((u >> 5) & 32'h3F) << 25) | (rs2 << 20) |
               (rs1 << 15) | (((u >> 1) & 32'hF) << 8) | (((u >> 11) & 32'h1) << 7) | 32'h63;
        end
        4'd13: begin
          bad = u[0] || s < -1048576 || s > 1048574;
          w0 = (((u >> 20) & 32'h1) << 31) | (((u >> 1) & 32'h3FF) << 21) |
               (((u >> 11) & 32'h1) << 20) | (((u >> 12) & 32'hFF) << 12) | (rd << 7) | 32'h6F;
        end
        4'd14: begin
          if (s >= -2048 && s <= 2047) begin
            w0 = ((u & 32'hFFF) << 20) | (rd << 7) | 32'h13;
          end else begin
            hi = (u + 32'h800) >> 12;
            lo = u & 32'hFFF;
            w0 = (hi << 12) | (rd << 7) | 32'h37;
            if (lo != 32'h0) begin
              nw = 2;
              w1 = (lo << 20) | (rd << 15) | (rd << 7) | 32'h13;
            end
          end
        end
        default: begin
          bad = u > 32'hFFF;
          w0 = ((u & 32'hFFF) << 20) | (rs1 << 15) | (32'd1 << 12) | (rd << 7) | 32'h73;
        end
      endcase
    end
    if (bad) nw = 0;
  endfunction

  task automatic apply_reset;
    rst_ni = 1'b0; req_valid_i = 1'b0; out_accept_i = 1'b0;
    req_op_i = '0; req_rd_i = '0; req_rs1_i = '0; req_rs2_i = '0; req_imm_i = '0;
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
  endtask

  task automatic drive_req(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                           input logic [4:0] rs2, input logic [31:0] imm);
    req_op_i = op; req_rd_i = rd; req_rs1_i = rs1; req_rs2_i = rs2; req_imm_i = imm;
    req_valid_i = 1'b1;
  endtask

  // Holds the request until accepted (bounded); returns -1 on timeout.
  task automatic issue(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [31:0] imm, output int waited);
    drive_req(op, rd, rs1, rs2, imm);
    waited = 0;
    #1;
    while (!req_ready_o && waited < 20) begin
      @(posedge clk_i); #1;
      waited++;
    end
    if (!req_ready_o) waited = -1;
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
  endtask

  task automatic test_reset;
    apply_reset;
    checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid_o); end
    checks++; if (out_opcode_o !== 32'h0) begin errors++; $display("FAIL reset_opcode: got %h expected 00000000", out_opcode_o); end
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err_o); end
    checks++; if (enc_count_o !== '0) begin errors++; $display("FAIL reset_count: got %0d expected 0", enc_count_o); end
    checks++; if (req_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", req_ready_o); end
  endtask

  task automatic test_encodings;
    int w;
    apply_reset;
    out_accept_i = 1'b1;
    issue(4'd0, 5'd1, 5'd2, 5'd3, 32'h0, w);
    checks++; if (w != 0) begin errors++; $display("FAIL add_wait: got %0d expected 0", w); end
    checks++; if (out_valid_o !== 1'b1 || out_opcode_o !== 32'h003100B3) begin errors++; $display("FAIL add_word: got %b/%h expected 1/003100B3", out_valid_o, out_opcode_o); end
    checks++; if (enc_count_o !== CNT_W'(1)) begin errors++; $display("FAIL add_count: got %0d expected 1", enc_count_o); end

    apply_reset;
    out_accept_i = 1'b1;
    issue(4'd14, 5'd5, 5'd0, 5'd0, 32'h12345678, w);
    checks++; if (out_valid_o !== 1'b1 || out_opcode_o !== 32'h123452B7) begin errors++; $display("FAIL li_lui: got %b/%h expected 1/123452B7", out_valid_o, out_opcode_o); end
    checks++; if (req_ready_o !== 1'b0) begin errors++; $display("FAIL li_ready_lo: got %b expected 0", req_ready_o); end
    @(posedge clk_i); #1;
    checks++; if (out_valid_o !== 1'b1 || out_opcode_o !== 32'h67828293) begin errors++; $display("FAIL li_addi: got %b/%h expected 1/67828293", out_valid_o, out_opcode_o); end
    checks++; if (enc_count_o !== CNT_W'(2)) begin errors++; $display("FAIL li_count: got %0d expected 2", enc_count_o); end
    checks++; if (req_ready_o !== 1'b1) begin errors++; $display("FAIL li_ready_back: got %b expected 1", req_ready_o); end
    @(posedge clk_i); #1;
    checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL li_drained: got %b expected 0", out_valid_o); end

    issue(4'd14, 5'd5, 5'd0, 5'd0, 32'hFFFFFFFF, w);
    checks++; if (out_valid_o !== 1'b1 || out_opcode_o !== 32'hFFF00293) begin errors++; $display("FAIL li_small: got %b/%h expected 1/FFF00293", out_valid_o, out_opcode_o); end
    @(posedge clk_i); #1;
    checks++; if (out_valid_o !== 1'b0 || enc_count_o !== CNT_W'(3)) begin errors++; $display("FAIL li_small_single: got %b/%0d expected 0/3", out_valid_o, enc_count_o); end

    issue(4'd14, 5'd6, 5'd0, 5'd0, 32'h00001000, w);
    checks++; if (out_valid_o !== 1'b1 || out_opcode_o !== 32'h00001337) begin errors++; $display("FAIL li_lo0: got %b/%h expected 1/00001337", out_valid_o, out_opcode_o); end
    checks++; if (req_ready_o !== 1'b1) begin errors++; $display("FAIL li_lo0_idle: got %b expected 1", req_ready_o); end
    @(posedge clk_i); #1;
    checks++; if (out_valid_o !== 1'b0 || enc_count_o !== CNT_W'(4)) begin errors++; $display("FAIL li_lo0_single: got %b/%0d expected 0/4", out_valid_o, enc_count_o); end
  endtask

  task automatic test_errors;
    int w;
    apply_reset;
    out_accept_i = 1'b1;
    issue(4'd12, 5'd0, 5'd1, 5'd2, 32'd3, w);
    checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL beq_err: got %b expected 1", err_o); end
    checks++; if (out_valid_o !== 1'b0 || enc_count_o !== '0) begin errors++; $display("FAIL beq_nopush: got %b/%0d expected 0/0", out_valid_o, enc_count_o); end
    @(posedge clk_i); #1;
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL beq_pulse: got %b expected 0", err_o); end
    issue(4'd8, 5'd1, 5'd1, 5'd0, 32'd2048, w);
    checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL addi_err: got %b expected 1", err_o); end
    checks++; if (out_valid_o !== 1'b0 || enc_count_o !== '0) begin errors++; $display("FAIL addi_nopush: got %b/%0d expected 0/0", out_valid_o, enc_count_o); end
    @(posedge clk_i); #1;
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL addi_pulse: got %b expected 0", err_o); end
  endtask

  task automatic test_back_to_back;
    int w;
    apply_reset;
    out_accept_i = 1'b0;
    issue(4'd0, 5'd1, 5'd2, 5'd3, 32'h0, w);
    checks++; if (w != 0) begin errors++; $display("FAIL stall_first_wait: got %0d expected 0", w); end
    drive_req(4'd0, 5'd4, 5'd5, 5'd6, 32'h0);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (req_ready_o !== 1'b0) begin errors++; $display("FAIL stall_ready: got %b expected 0", req_ready_o); end
      checks++; if (out_valid_o !== 1'b1 || out_opcode_o !== 32'h003100B3 || enc_count_o !== CNT_W'(1)) begin errors++; $display("FAIL stall_head: got %b/%h/%0d expected 1/003100B3/1", out_valid_o, out_opcode_o, enc_count_o); end
      @(posedge clk_i); #1;
    end
    out_accept_i = 1'b1;
    #1;
    checks++; if (req_ready_o !== 1'b1) begin errors++; $display("FAIL stall_release: got %b expected 1", req_ready_o); end
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    checks++; if (out_valid_o !== 1'b1 || out_opcode_o !== 32'h00628233 || enc_count_o !== CNT_W'(2)) begin errors++; $display("FAIL stall_second: got %b/%h/%0d expected 1/00628233/2", out_valid_o, out_opcode_o, enc_count_o); end
    @(posedge clk_i); #1;
    checks++; if (out_valid_o !== 1'b0 || enc_count_o !== CNT_W'(2)) begin errors++; $display("FAIL stall_nodup: got %b/%0d expected 0/2", out_valid_o, enc_count_o); end
    out_accept_i = 1'b0;
  endtask

  task automatic test_reset_in_li_lo;
    int w;
    apply_reset;
    out_accept_i = 1'b0;
    issue(4'd14, 5'd5, 5'd0, 5'd0, 32'h12345678, w);
    rst_ni = 1'b0;
    @(posedge clk_i); #1;
    checks++; if (out_valid_o !== 1'b0 || out_opcode_o !== 32'h0) begin errors++; $display("FAIL lilo_rst_fifo: got %b/%h expected 0/00000000", out_valid_o, out_opcode_o); end
    checks++; if (enc_count_o !== '0) begin errors++; $display("FAIL lilo_rst_count: got %0d expected 0", enc_count_o); end
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    checks++; if (out_valid_o !== 1'b0 || req_ready_o !== 1'b1) begin errors++; $display("FAIL lilo_rst_idle: got valid %b ready %b expected 0/1", out_valid_o, req_ready_o); end
  endtask

  task automatic test_random;
    logic [31:0] q[$];
    logic [31:0] w0, w1, li_word, imm;
    logic [CNT_W-1:0] cnt_exp;
    int nw, t;
    bit bad, err_exp, li_pend, holding, pop, ready_exp;
    int bnd[12] = '{2047, 2048, -2048, -2049, 4094, 4095, -4096, -4098,
                    1048574, 1048576, -1048576, 0};
    apply_reset;
    err_exp = 1'b0; li_pend = 1'b0; holding = 1'b0; cnt_exp = '0; li_word = 32'h0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      checks++; if (err_o !== err_exp) begin errors++; $display("FAIL rnd_err cyc %0d: got %b expected %b", cyc, err_o, err_exp); end
      checks++; if (out_valid_o !== (q.size() != 0)) begin errors++; $display("FAIL rnd_valid cyc %0d: got %b expected %b", cyc, out_valid_o, q.size() != 0); end
      if (q.size() != 0) begin
        checks++; if (out_opcode_o !== q[0]) begin errors++; $display("FAIL rnd_word cyc %0d: got %h expected %h", cyc, out_opcode_o, q[0]); end
      end
      checks++; if (enc_count_o !== cnt_exp) begin errors++; $display("FAIL rnd_count cyc %0d: got %0d expected %0d", cyc, enc_count_o, cnt_exp); end
      if (!holding && $urandom_range(0, 9) < 7) begin
        case ($urandom_range(0, 5))
          0: begin t = int'($urandom_range(0, 4095)) - 2048; imm = 32'(t); end
          1: imm = $urandom;
          2: imm = 32'(bnd[$urandom_range(0, 11)]);
          3: imm = $urandom & 32'hFFFFF000;
          4: imm = 32'($urandom_range(0, 8191));
          default: begin t = int'($urandom_range(0, 2097151)) - 1048576; imm = 32'(t); end
        endcase
        drive_req(4'($urandom_range(0, 15)), 5'($urandom_range(0, 31)),
                  5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), imm);
        holding = 1'b1;
      end
      req_valid_i = holding;
      out_accept_i = ($urandom_range(0, 9) < 6);
      #1;
      pop = out_accept_i && (q.size() != 0);
      ready_exp = !li_pend && (q.size() == 0 || (q.size() == 1 && pop));
      checks++; if (req_ready_o !== ready_exp) begin errors++; $display("FAIL rnd_ready cyc %0d: got %b expected %b", cyc, req_ready_o, ready_exp); end
      if (pop) void'(q.pop_front());
      err_exp = 1'b0;
      if (li_pend) begin
        q.push_back(li_word);
        cnt_exp++;
        li_pend = 1'b0;
      end else if (holding && ready_exp) begin
        model_encode(req_op_i, 32'(req_rd_i), 32'(req_rs1_i), 32'(req_rs2_i), req_imm_i,
                     w0, w1, nw, bad);
        if (bad) begin
          err_exp = 1'b1;
        end else begin
          q.push_back(w0);
          cnt_exp++;
        end
        if (nw == 2) begin
          li_pend = 1'b1;
          li_word = w1;
        end
        holding = 1'b0;
      end
      @(posedge clk_i); #1;
    end
    req_valid_i = 1'b0;
    out_accept_i = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion expected finish within time limit");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    rst_ni = 1'b0; req_valid_i = 1'b0; out_accept_i = 1'b0;
    req_op_i = '0; req_rd_i = '0; req_rs1_i = '0; req_rs2_i = '0; req_imm_i = '0;
    test_reset;
    test_encodings;
    test_errors;
    test_back_to_back;
    test_reset_in_li_lo;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
